// File: rtl/uart_tx_stream.sv
// Byte-stream UART transmitter: start, 8 data bits LSB-first,
// optional even parity, 1 or 2 stop bits, registered outputs.
module uart_tx_stream #(
    parameter int CLK_DIV   = 434,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_in_valid,
    input  logic [7:0] data_in,
    output logic       data_in_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;
    logic          hs;
    logic          bit_end;

    assign hs      = data_in_valid & rdy_q;
    assign bit_end = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = START;
                    shift_d = data_in;
                    par_d   = ^data_in;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q != STOP_LAST) begin
                        idx_d = idx_q + 3'd1;
                    end else if (hs) begin
                        // Back-to-back: next start bit follows with no idle gap
                        state_d = START;
                        shift_d = data_in;
                        par_d   = ^data_in;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from next state so the registers line up with it
    always_comb begin
        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == IDLE) ||
                 ((state_d == STOP) && (cnt_d == CNT_MAX) &&
                  (idx_d == STOP_LAST));
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign data_in_ready = rdy_q;
    assign tx            = tx_q;
    assign tx_busy       = busy_q;

endmodule
